control_out_capture: RTL

Synthesizable, parametrised capture engine for the LC-3 controller output vector, the successor to the control_out monitor. Each clock it samples a packed control vector (enables, br_taken, bypass selects, mem_state). It timestamps every sample, or only those that differ from the previous one, and buffers them in a first-word-fall-through FIFO drained by a valid/ready consumer. Overflow is counted and flagged in-band, so software or scoreboards see exactly where history was lost.

---
 rtl/control_out_capture_pkg.sv | 16 +
 rtl/capture_fifo.sv | 57 +++++
 rtl/control_out_capture.sv | 100 ++++++++++
 3 files changed

// File: rtl/control_out_capture_pkg.sv
// Shared types and layout helpers for the LC-3 control-vector capture engine.
package control_out_capture_pkg;

  typedef enum logic {
    CAP_ALL    = 1'b0,
    CAP_CHANGE = 1'b1
  } capture_mode_e;

  localparam int DROP_CNT_W = 16;

  // Entry layout is {sample, timestamp, gap}.
  function automatic int entry_w(input int width, input int ts_width);
    return width + ts_width + 1;
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous first-word-fall-through FIFO; accepts a push when full if a pop
// retires the head in the same cycle.
module capture_fifo #(
  parameter int W     = 29,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         pop_ok;
  logic         push_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // When full, the write slot is the head slot; the head is read out before
  // the edge that overwrites it, so push-with-pop is safe.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      // NOTE: storage is cleared so the stale head reads as zero after reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/control_out_capture.sv
// Timestamped capture of the LC-3 controller output vector into a FWFT FIFO,
// with change-only filtering, in-band gap marking and saturating drop count.
module control_out_capture
  import control_out_capture_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [WIDTH-1:0]          sample_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [TS_WIDTH-1:0]       out_ts,
  output logic                      out_gap,
  output logic [$clog2(DEPTH):0]    level,
  output logic [DROP_CNT_W-1:0]     drop_count
);

  localparam int ENTRY_W = entry_w(WIDTH, TS_WIDTH);

  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [WIDTH-1:0]      last_q, last_d;
  logic                  first_q, first_d;
  logic                  gap_q, gap_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic                  capture;
  logic                  pop;
  logic                  drop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [ENTRY_W-1:0]    wdata;
  logic [ENTRY_W-1:0]    rdata;

  assign pop     = out_valid && out_ready;
  assign capture = enable && ((capture_mode_e'(mode) == CAP_ALL) || first_q ||
                              (sample_in != last_q));
  assign drop    = capture && fifo_full && !pop;
  assign wdata   = {sample_in, ts_q, gap_q};

  always_comb begin
    // NOTE: every next-state value gets a default first so no latch is inferred.
    ts_d    = ts_q + 1'b1;
    last_d  = last_q;
    first_d = !enable;
    gap_d   = gap_q;
    drop_d  = drop_q;
    if (enable) last_d = sample_in;
    if (drop) begin
      gap_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + 1'b1;
    end else if (capture) begin
      gap_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q    <= '0;
      last_q  <= '0;
      first_q <= 1'b1;
      gap_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      ts_q    <= ts_d;
      last_q  <= last_d;
      first_q <= first_d;
      gap_q   <= gap_d;
      drop_q  <= drop_d;
    end
  end

  capture_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (capture),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (level)
  );

  assign out_valid  = !fifo_empty;
  assign out_data   = rdata[ENTRY_W-1 -: WIDTH];
  assign out_ts     = rdata[TS_WIDTH:1];
  assign out_gap    = rdata[0];
  assign drop_count = drop_q;

endmodule
